// File: rtl/note_fetch_arbiter.sv
// Arbitrates per-lane chart-word fetches onto one synchronous-read memory and owns every lane's read pointer.
// Define NOTE_ARB_FIXED_PRIO_EN for fixed lowest-index priority; round-robin otherwise.
module note_fetch_arbiter #(
  parameter int LANES  = 5,
  parameter int PTR_W  = 10,
  parameter int RD_LAT = 2,
  parameter int LANE_W = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    restart,
  input  logic [LANES-1:0]        note_request,
  output logic [LANES-1:0]        note_available,
  output logic [15:0]             note_time,
  output logic                    mem_rd,
  output logic [LANE_W+PTR_W-1:0] mem_addr,
  input  logic [15:0]             mem_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  localparam logic [15:0]       SENTINEL  = 16'hFFFF;
  localparam logic [PTR_W-1:0]  PTR_MAX   = '1;
  localparam logic [2:0]        LAST_CNT  = 3'(RD_LAT - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [LANES-1:0]  LANE0_BIT = {{(LANES-1){1'b0}}, 1'b1};

  state_t                    state_q;
  logic [LANE_W-1:0]         lane_q;
  logic [PTR_W-1:0]          ptr_q [LANES];
  logic [LANES-1:0]          exhausted_q;
  logic [2:0]                waitCnt_q;
  logic [LANES-1:0]          avail_q;
  logic [15:0]               noteTime_q;
  logic                      memRd_q;
  logic [LANE_W+PTR_W-1:0]   memAddr_q;

  logic                      anyReq;
  logic [LANES-1:0]          searchReq;
  logic [LANE_W-1:0]         winLane;

  assign anyReq = |note_request;

`ifdef NOTE_ARB_FIXED_PRIO_EN
  assign searchReq = note_request;
`else
  logic [LANE_W-1:0] rrLast_q;
  logic [LANES-1:0]  reqHi;

  // Lanes above the last served one take precedence; if none pend, wrap to the full set.
  always_comb begin
    reqHi = '0;
    for (int j = 0; j < LANES; j++) begin
      reqHi[j] = note_request[j] && (LANE_W'(j) > rrLast_q);
    end
  end

  assign searchReq = (|reqHi) ? reqHi : note_request;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrLast_q <= LAST_LANE;
    end else if (restart) begin
      rrLast_q <= LAST_LANE;
    end else if (state_q == IDLE && anyReq) begin
      rrLast_q <= winLane;
    end
  end
`endif

  always_comb begin
    winLane = '0;
    for (int j = LANES - 1; j >= 0; j--) begin
      if (searchReq[j]) winLane = LANE_W'(j);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      exhausted_q <= '0;
      waitCnt_q   <= '0;
      avail_q     <= '0;
      noteTime_q  <= SENTINEL;
      memRd_q     <= 1'b0;
      memAddr_q   <= '0;
      for (int i = 0; i < LANES; i++) ptr_q[i] <= '0;
    end else if (restart) begin
      // Abort whatever is in flight; note_time keeps its last delivered word.
      state_q     <= IDLE;
      exhausted_q <= '0;
      waitCnt_q   <= '0;
      avail_q     <= '0;
      memRd_q     <= 1'b0;
      for (int i = 0; i < LANES; i++) ptr_q[i] <= '0;
    end else begin
      avail_q <= '0;
      memRd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            lane_q  <= winLane;
            state_q <= ISSUE;
            if (!exhausted_q[winLane]) begin
              memRd_q   <= 1'b1;
              memAddr_q <= {winLane, ptr_q[winLane]};
            end
          end
        end
        ISSUE: begin
          if (exhausted_q[lane_q]) begin
            noteTime_q <= SENTINEL;
            avail_q    <= LANE0_BIT << lane_q;
            state_q    <= DELIVER;
          end else begin
            waitCnt_q <= '0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (waitCnt_q == LAST_CNT) begin
            noteTime_q <= mem_data;
            avail_q    <= LANE0_BIT << lane_q;
            state_q    <= DELIVER;
          end else begin
            waitCnt_q <= waitCnt_q + 3'd1;
          end
        end
        DELIVER: begin
          // A sentinel parks the pointer; the last real word at the top saturates instead of wrapping.
          if (noteTime_q != SENTINEL) begin
            if (ptr_q[lane_q] == PTR_MAX) exhausted_q[lane_q] <= 1'b1;
            else ptr_q[lane_q] <= ptr_q[lane_q] + 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign note_available = avail_q;
  assign note_time      = noteTime_q;
  assign mem_rd         = memRd_q;
  assign mem_addr       = memAddr_q;

endmodule

// File: tb/tb_note_fetch_arbiter.sv
// Scoreboard bench for note_fetch_arbiter with a latency-accurate chart memory model.
module tb_note_fetch_arbiter;

  localparam int LANES  = 5;
  localparam int PTR_W  = 3;
  localparam int RD_LAT = 2;
  localparam int AW     = 6;

  typedef struct packed {
    logic [4:0]  vec;
    logic [15:0] word;
    logic [5:0]  addr;
    logic        noRead;
  } xactT;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             restart;
  logic [LANES-1:0] note_request;
  logic [LANES-1:0] note_available;
  logic [15:0]      note_time;
  logic             mem_rd;
  logic [AW-1:0]    mem_addr;
  logic [15:0]      mem_data;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0]  mem [0:63];
  logic [2:0]   modelPtr [LANES];
  logic [4:0]   modelExh;
  xactT         sb [$];

  logic [AW-1:0] addrPipe [1:RD_LAT];
  logic          vPipe    [1:RD_LAT];

  note_fetch_arbiter #(.LANES(LANES), .PTR_W(PTR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .note_request(note_request),
    .note_available(note_available), .note_time(note_time), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Chart memory: data for a read strobe appears exactly RD_LAT cycles later, garbage otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= RD_LAT; i++) begin
        vPipe[i] <= 1'b0;
        addrPipe[i] <= '0;
      end
    end else begin
      vPipe[1] <= mem_rd;
      addrPipe[1] <= mem_addr;
      for (int i = 2; i <= RD_LAT; i++) begin
        vPipe[i] <= vPipe[i-1];
        addrPipe[i] <= addrPipe[i-1];
      end
    end
  end

  assign mem_data = vPipe[RD_LAT] ? mem[addrPipe[RD_LAT]] : 16'hDEAD;

  function automatic void modelReset();
    for (int i = 0; i < LANES; i++) modelPtr[i] = '0;
    modelExh = '0;
  endfunction

  function automatic xactT predict(input int lane);
    xactT e;
    logic [2:0] ln;
    ln = 3'(lane);
    e.vec = 5'(1) << lane;
    e.noRead = modelExh[lane];
    e.addr = e.noRead ? 6'd0 : {ln, modelPtr[lane]};
    e.word = e.noRead ? 16'hFFFF : mem[{ln, modelPtr[lane]}];
    if (e.word != 16'hFFFF) begin
      if (modelPtr[lane] == 3'd7) modelExh[lane] = 1'b1;
      else modelPtr[lane] = modelPtr[lane] + 3'd1;
    end
    return e;
  endfunction

  // Raises one lane's request, records what the DUT does, and drops it on the edge ending the pulse.
  task automatic serveOne(input int lane, output xactT got, output int rdCyc, output int availCyc);
    got = '0;
    rdCyc = -1;
    availCyc = -1;
    @(posedge clk); #1;
    note_request[lane] = 1'b1;
    for (int c = 0; c < 20 && availCyc < 0; c++) begin
      @(negedge clk);
      if (mem_rd && rdCyc < 0) begin
        rdCyc = c;
        got.addr = mem_addr;
      end
      if (note_available != '0) begin
        availCyc = c;
        got.vec = note_available;
        got.word = note_time;
      end
    end
    got.noRead = (rdCyc < 0);
    @(posedge clk); #1;
    note_request[lane] = 1'b0;
  endtask

  task automatic pulseRestart();
    @(posedge clk); #1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (note_available !== 5'b0 || note_time !== 16'hFFFF || mem_rd !== 1'b0 || mem_addr !== 6'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got avail=%b time=%h rd=%b addr=%h, want 00000 ffff 0 00",
               note_available, note_time, mem_rd, mem_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_lane();
    xactT e, got;
    int rdCyc, availCyc;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(predict(2));
      serveOne(2, got, rdCyc, availCyc);
      e = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL single_lane[%0d]: got %h, want %h", k, got, e);
      end
      vectors++;
      if (rdCyc !== 1 || availCyc !== RD_LAT + 2) begin
        miscompares++;
        $display("[TB] FAIL single_lane_timing[%0d]: got rd@%0d avail@%0d, want rd@1 avail@%0d",
                 k, rdCyc, availCyc, RD_LAT + 2);
      end
    end
  endtask

  task automatic test_contention();
    xactT e;
    int order [6];
    int grants, last;
    logic [LANES-1:0] dropMask, reraise;
`ifdef NOTE_ARB_FIXED_PRIO_EN
    order = '{0, 1, 0, 1, 0, 1};
`else
    order = '{0, 1, 4, 0, 1, 4};
`endif
    pulseRestart();
    for (int k = 0; k < 6; k++) sb.push_back(predict(order[k]));
    grants = 0;
    last = 0;
    reraise = '0;
    @(posedge clk); #1;
    note_request = 5'b10011;
    for (int c = 0; c < 60 && grants < 6; c++) begin
      @(negedge clk);
      dropMask = '0;
      if (note_available != '0) begin
        e = sb.pop_front();
        vectors++;
        if (note_available !== e.vec || note_time !== e.word) begin
          miscompares++;
          $display("[TB] FAIL contention_grant[%0d]: got avail=%b time=%h, want %b %h",
                   grants, note_available, note_time, e.vec, e.word);
        end
        if (grants > 0) begin
          vectors++;
          if (c - last !== RD_LAT + 3) begin
            miscompares++;
            $display("[TB] FAIL contention_spacing[%0d]: got %0d cycles, want %0d", grants, c - last, RD_LAT + 3);
          end
        end
        last = c;
        grants++;
        dropMask = note_available;
      end
      @(posedge clk); #1;
      note_request = (note_request & ~dropMask) | reraise;
      reraise = dropMask;
    end
    note_request = '0;
    vectors++;
    if (grants !== 6) begin
      miscompares++;
      $display("[TB] FAIL contention_count: got %0d grants, want 6", grants);
    end
    sb.delete();
  endtask

  task automatic test_lane_drain(input int lane, input int extra, input string name);
    xactT e, got;
    int rdCyc, availCyc, n;
    n = 0;
    while (!modelExh[lane] && !(modelPtr[lane] == 3'd7 && mem[{3'(lane), 3'd7}] == 16'hFFFF)) begin
      sb.push_back(predict(lane));
      serveOne(lane, got, rdCyc, availCyc);
      e = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL %s_fill[%0d]: got %h, want %h", name, n, got, e);
      end
      n++;
    end
    for (int k = 0; k < extra; k++) begin
      sb.push_back(predict(lane));
      serveOne(lane, got, rdCyc, availCyc);
      e = sb.pop_front();
      vectors++;
      if (got !== e || got.word !== 16'hFFFF) begin
        miscompares++;
        $display("[TB] FAIL %s_end[%0d]: got %h, want %h", name, k, got, e);
      end
      vectors++;
      if (availCyc !== (e.noRead ? 2 : RD_LAT + 2) || rdCyc !== (e.noRead ? -1 : 1)) begin
        miscompares++;
        $display("[TB] FAIL %s_end_timing[%0d]: got rd@%0d avail@%0d, noRead=%b",
                 name, k, rdCyc, availCyc, e.noRead);
      end
    end
  endtask

  task automatic test_sentinel();
    test_lane_drain(3, 4, "sentinel");
  endtask

  task automatic test_saturation();
    test_lane_drain(1, 1, "saturation");
  endtask

  task automatic test_restart_wait();
    xactT e, got;
    int rdCyc, availCyc;
    logic sawPulse;
    while (modelPtr[0] < 3'd5) begin
      e = predict(0);
      serveOne(0, got, rdCyc, availCyc);
    end
    @(posedge clk); #1;
    note_request[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (mem_rd !== 1'b1 || mem_addr !== 6'o05) begin
      miscompares++;
      $display("[TB] FAIL restart_pre_read: got rd=%b addr=%h, want 1 05", mem_rd, mem_addr);
    end
    @(posedge clk); #1;
    restart = 1'b1;
    note_request[0] = 1'b0;
    @(posedge clk); #1;
    restart = 1'b0;
    modelReset();
    sawPulse = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (note_available != '0) sawPulse = 1'b1;
    end
    vectors++;
    if (sawPulse !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL restart_abort: got a note_available pulse, want none");
    end
    for (int k = 0; k < 2; k++) begin
      sb.push_back(predict(k));
      serveOne(k, got, rdCyc, availCyc);
      e = sb.pop_front();
      vectors++;
      if (got !== e || rdCyc !== 1) begin
        miscompares++;
        $display("[TB] FAIL restart_after_lane%0d: got %h rd@%0d, want %h rd@1", k, got, rdCyc, e);
      end
    end
  endtask

  task automatic test_async_reset();
    xactT e, got;
    int rdCyc, availCyc;
    @(posedge clk); #1;
    note_request[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (mem_rd !== 1'b1 || note_time === 16'hFFFF) begin
      miscompares++;
      $display("[TB] FAIL areset_pre: got rd=%b time=%h, want rd=1 and a non-sentinel word", mem_rd, note_time);
    end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_rd !== 1'b0 || note_time !== 16'hFFFF || note_available !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL areset_immediate: got rd=%b time=%h avail=%b, want 0 ffff 00000",
               mem_rd, note_time, note_available);
    end
    note_request = '0;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    sb.push_back(predict(2));
    serveOne(2, got, rdCyc, availCyc);
    e = sb.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("[TB] FAIL areset_recover: got %h, want %h", got, e);
    end
  endtask

  initial begin
    for (int a = 0; a < 64; a++) mem[a] = 16'h1000 + 16'(a * 3);
    mem[6'o20] = 16'h0123;
    mem[6'o37] = 16'hFFFF;
    modelReset();
    rst_n = 1'b0;
    restart = 1'b0;
    note_request = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single_lane();
    test_contention();
    test_sentinel();
    test_saturation();
    test_restart_wait();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
